// File: rtl/mem_flit_packetizer_if.sv
// mem_flit_packetizer_if
// Bundles the cache-side request handshake and the router-side flit port of
// mem_flit_packetizer.
//   req_valid/req_ready  request handshake (push when both high)
//   req_write            1 = write (head+tail), 0 = read (single flit)
//   req_msg/dest/addr    request header fields
//   req_data             write payload
//   flit_out/valid_out   registered flit towards the router local port
//   full_in              per-VC full from the router
// Modports: slave = packetizer side, master = cache/router environment side.
interface mem_flit_packetizer_if #(
    parameter int ID_BITS      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int MSG_BITS     = 3,
    parameter int VC_BITS      = 1,
    parameter int EXTRA        = 2,
    parameter int TYPE_BITS    = 2
);
    localparam int VC_PER_PORTS = 1 << VC_BITS;
    localparam int FLOW_BITS    = 2 * ID_BITS + EXTRA;
    localparam int FLIT_WIDTH   = FLOW_BITS + TYPE_BITS + VC_BITS + DATA_WIDTH;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [MSG_BITS-1:0]     req_msg;
    logic [ID_BITS-1:0]      req_dest;
    logic [ADDRESS_BITS-1:0] req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [FLIT_WIDTH-1:0]   flit_out;
    logic                    valid_out;
    logic [VC_PER_PORTS-1:0] full_in;

    modport slave (
        input  req_valid, req_write, req_msg, req_dest, req_addr, req_data, full_in,
        output req_ready, flit_out, valid_out
    );

    modport master (
        output req_valid, req_write, req_msg, req_dest, req_addr, req_data, full_in,
        input  req_ready, flit_out, valid_out
    );
endinterface

// File: rtl/mem_flit_packetizer.sv
// mem_flit_packetizer
// Queues cache memory requests in a small FIFO and turns each one into
// wormhole flits for the router local port: a SINGLE flit for a read, a
// HEAD+TAIL pair for a write. A packet is bound to the lowest free VC when its
// first flit issues and stays on that VC until its tail leaves.
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   core_ID       source router ID placed in the flow field
//   bus           request handshake + flit port (see mem_flit_packetizer_if)
//   packets_sent  count of completed packets (SINGLE or TAIL issued), wraps
//
// state  | meaning
// IDLE   | waiting for a queued request and a free VC; issues SINGLE or HEAD
// TAIL   | write head sent; waiting for the locked VC to issue the TAIL
module mem_flit_packetizer #(
    parameter int ID_BITS      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int MSG_BITS     = 3,
    parameter int VC_BITS      = 1,
    parameter int EXTRA        = 2,
    parameter int TYPE_BITS    = 2,
    parameter int QUEUE_BITS   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ID_BITS-1:0]    core_ID,
    mem_flit_packetizer_if.slave  bus,
    output logic [31:0]           packets_sent
);
    localparam int VC_PER_PORTS = 1 << VC_BITS;
    localparam int DEPTH        = 1 << QUEUE_BITS;
    localparam int FLOW_BITS    = 2 * ID_BITS + EXTRA;
    localparam int FLIT_WIDTH   = FLOW_BITS + TYPE_BITS + VC_BITS + DATA_WIDTH;

    localparam logic [TYPE_BITS-1:0] T_HEAD   = TYPE_BITS'(2'b10);
    localparam logic [TYPE_BITS-1:0] T_TAIL   = TYPE_BITS'(2'b01);
    localparam logic [TYPE_BITS-1:0] T_SINGLE = TYPE_BITS'(2'b11);

    typedef enum logic {S_IDLE, S_TAIL} state_t;

    // Request FIFO
    logic                    wr_mem   [DEPTH];
    logic [MSG_BITS-1:0]     msg_mem  [DEPTH];
    logic [ID_BITS-1:0]      dest_mem [DEPTH];
    logic [ADDRESS_BITS-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem [DEPTH];

    logic [QUEUE_BITS-1:0] rd_ptr_q, wr_ptr_q;
    logic [QUEUE_BITS:0]   count_q;
    logic                  fifo_empty, fifo_full, push, pop;

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == (QUEUE_BITS+1)'(DEPTH));
    assign bus.req_ready = !fifo_full;
    assign push          = bus.req_valid && !fifo_full;

    always_ff @(posedge clock) begin
        if (push) begin
            wr_mem[wr_ptr_q]   <= bus.req_write;
            msg_mem[wr_ptr_q]  <= bus.req_msg;
            dest_mem[wr_ptr_q] <= bus.req_dest;
            addr_mem[wr_ptr_q] <= bus.req_addr;
            data_mem[wr_ptr_q] <= bus.req_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + QUEUE_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + QUEUE_BITS'(1);
            if (push && !pop)      count_q <= count_q + (QUEUE_BITS+1)'(1);
            else if (pop && !push) count_q <= count_q - (QUEUE_BITS+1)'(1);
        end
    end

    // Lowest-index VC that the router reports as not full
    logic               vc_free;
    logic [VC_BITS-1:0] free_vc;

    always_comb begin
        vc_free = 1'b0;
        free_vc = '0;
        for (int i = VC_PER_PORTS - 1; i >= 0; i--) begin
            if (!bus.full_in[i]) begin
                vc_free = 1'b1;
                free_vc = VC_BITS'(i);
            end
        end
    end

    // FSM
    state_t             state_q, state_d;
    logic [VC_BITS-1:0] vc_q, vc_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vc_d    = vc_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && vc_free) begin
                    vc_d = free_vc;
                    if (wr_mem[rd_ptr_q]) state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (!bus.full_in[vc_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic                  issue;
    logic [TYPE_BITS-1:0]  flit_type;
    logic [VC_BITS-1:0]    flit_vc;
    logic [DATA_WIDTH-1:0] flit_data;

    always_comb begin
        issue     = 1'b0;
        pop       = 1'b0;
        flit_type = T_SINGLE;
        flit_vc   = vc_q;
        flit_data = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && vc_free) begin
                    issue     = 1'b1;
                    flit_vc   = free_vc;
                    flit_type = wr_mem[rd_ptr_q] ? T_HEAD : T_SINGLE;
                    flit_data = DATA_WIDTH'({msg_mem[rd_ptr_q], addr_mem[rd_ptr_q]});
                    // A write keeps its entry until the tail, which needs req_data
                    pop       = !wr_mem[rd_ptr_q];
                end
            end
            S_TAIL: begin
                if (!bus.full_in[vc_q]) begin
                    issue     = 1'b1;
                    pop       = 1'b1;
                    flit_type = T_TAIL;
                    flit_data = data_mem[rd_ptr_q];
                end
            end
            default: ;
        endcase
    end

    // Registered flit port and packet counter
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;
    logic                  valid_q;
    logic [31:0]           pkt_cnt_q, pkt_cnt_d;
    logic [FLOW_BITS-1:0]  flow;

    assign flow      = {core_ID, dest_mem[rd_ptr_q], {EXTRA{1'b0}}};
    assign flit_d    = issue ? {flow, flit_type, flit_vc, flit_data} : flit_q;
    assign pkt_cnt_d = (issue && pop) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flit_q    <= '0;
            valid_q   <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            flit_q    <= flit_d;
            valid_q   <= issue;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.flit_out  = flit_q;
    assign bus.valid_out = valid_q;
    assign packets_sent  = pkt_cnt_q;
endmodule

// File: tb/tb_mem_flit_packetizer.sv
// tb_mem_flit_packetizer
// Scoreboard bench: each accepted request pushes its expected flits; a
// negedge monitor pops and compares every valid flit, checks the VC choice
// against the full_in seen at the issuing edge, and tracks packets_sent.
module tb_mem_flit_packetizer;
    localparam int FW = 45;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  core_ID;
    logic [31:0] packets_sent;

    mem_flit_packetizer_if bus ();

    mem_flit_packetizer dut (
        .clock        (clock),
        .reset        (reset),
        .core_ID      (core_ID),
        .bus          (bus),
        .packets_sent (packets_sent)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  ftype;
        logic [9:0]  flow;
        logic [31:0] data;
        bit          first;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor
    logic [1:0]  full_at_edge = 2'b00;
    logic        locked_vc = 1'b0;
    exp_t        m_e;
    logic        m_vc;
    logic [1:0]  m_type;

    always @(posedge clock) full_at_edge <= bus.full_in;

    always @(negedge clock) begin
        if (!reset && bus.valid_out) begin
            m_type = bus.flit_out[34:33];
            m_vc   = bus.flit_out[32];
            if (exp_q.size() == 0) begin
                fail_now("unexpected_flit", bus.flit_out, 0);
            end else begin
                m_e = exp_q.pop_front();
                check("flit_type", m_type, m_e.ftype);
                check("flit_flow", bus.flit_out[44:35], m_e.flow);
                check("flit_data", bus.flit_out[31:0], m_e.data);
                if (m_e.first) begin
                    if (!full_at_edge[0])      check("first_vc", m_vc, 0);
                    else if (!full_at_edge[1]) check("first_vc", m_vc, 1);
                    else fail_now("first_vc_no_free", {62'd0, full_at_edge}, 0);
                    locked_vc = m_vc;
                end else begin
                    check("locked_vc", m_vc, locked_vc);
                end
                check("vc_not_full_at_issue", full_at_edge[m_vc], 0);
                if (m_e.ftype == 2'b11 || m_e.ftype == 2'b01) begin
                    model_cnt = model_cnt + 32'd1;
                    check("packets_sent", packets_sent, model_cnt);
                end
            end
        end
    end

    // Called just after a negedge; returns just after a negedge with req_valid low.
    task automatic send(input bit wr, input logic [2:0] msg, input logic [3:0] dest,
                        input logic [19:0] addr, input logic [31:0] data);
        bit   acc = 0;
        int   t   = 0;
        exp_t e;
        bus.req_write = wr;
        bus.req_msg   = msg;
        bus.req_dest  = dest;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_valid = 1'b1;
        while (!acc && t < 300) begin
            acc = bus.req_ready;
            @(posedge clock);
            if (acc) begin
                e.flow  = {core_ID, dest, 2'b00};
                e.data  = {9'd0, msg, addr};
                e.first = 1;
                e.ftype = wr ? 2'b10 : 2'b11;
                exp_q.push_back(e);
                if (wr) begin
                    e.ftype = 2'b01;
                    e.data  = data;
                    e.first = 0;
                    exp_q.push_back(e);
                end
            end
            @(negedge clock);
            t++;
        end
        if (!acc) fail_now("request_accept_timeout", t, 0);
        bus.req_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [44:0] exp_flit;
    logic        head_vc;
    bit          rand_done;

    initial begin
        reset         = 1'b1;
        core_ID       = 4'd1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_msg   = '0;
        bus.req_dest  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.full_in   = 2'b00;
        cycles(3);
        check("reset_valid", bus.valid_out, 0);
        check("reset_flit", bus.flit_out, 0);
        check("reset_count", packets_sent, 0);
        check("reset_ready", bus.req_ready, 1);
        reset = 1'b0;
        cycles(2);

        // Single read: valid two cycles after accept
        send(0, 3'd3, 4'd5, 20'h12345, 32'h0);
        check("read_not_yet_valid", bus.valid_out, 0);
        @(negedge clock);
        exp_flit = {10'h054, 2'b11, 1'b0, 32'h00312345};
        check("read_valid", bus.valid_out, 1);
        check("read_flit", bus.flit_out, exp_flit);
        check("read_count", packets_sent, 1);
        cycles(2);

        // Write, no back-pressure: HEAD then TAIL on consecutive cycles
        send(1, 3'd1, 4'd2, 20'h00010, 32'hDEADBEEF);
        @(negedge clock);
        check("wr_head_valid", bus.valid_out, 1);
        check("wr_head_type", bus.flit_out[34:33], 2'b10);
        head_vc = bus.flit_out[32];
        @(negedge clock);
        check("wr_tail_valid", bus.valid_out, 1);
        check("wr_tail_type", bus.flit_out[34:33], 2'b01);
        check("wr_tail_data", bus.flit_out[31:0], 32'hDEADBEEF);
        check("wr_tail_vc", bus.flit_out[32], head_vc);
        cycles(2);

        // Write on VC1, tail stalled three cycles, stays on VC1 after VC0 frees
        bus.full_in = 2'b01;
        send(1, 3'd2, 4'd7, 20'hABCDE, 32'h01234567);
        @(negedge clock);
        check("vc1_head_valid", bus.valid_out, 1);
        check("vc1_head_vc", bus.flit_out[32], 1);
        bus.full_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("vc1_tail_stalled", bus.valid_out, 0);
        end
        bus.full_in = 2'b00;
        @(negedge clock);
        check("vc1_tail_valid", bus.valid_out, 1);
        check("vc1_tail_vc", bus.flit_out[32], 1);
        check("vc1_tail_type", bus.flit_out[34:33], 2'b01);
        cycles(2);

        // FIFO fills to depth under full back-pressure
        bus.full_in = 2'b11;
        for (int i = 0; i < 4; i++) send(0, 3'(i), 4'(i + 8), 20'(i * 4096 + 7), 32'h0);
        bus.req_write = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        check("fifo_full_ready", bus.req_ready, 0);
        bus.full_in = 2'b00;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clock);
                    check("burst_valid", bus.valid_out, 1);
                end
            end
            send(0, 3'd4, 4'd12, 20'h55555, 32'h0);
        join
        cycles(3);

        // Reset between HEAD and TAIL
        send(1, 3'd5, 4'd3, 20'h00F00, 32'hCAFEF00D);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_valid", bus.valid_out, 0);
        check("midreset_count", packets_sent, 0);
        check("midreset_ready", bus.req_ready, 1);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_reset_idle", bus.valid_out, 0);
        end
        send(0, 3'd6, 4'd9, 20'h0BEEF, 32'h0);
        @(negedge clock);
        check("post_reset_single", bus.flit_out[34:33], 2'b11);
        check("post_reset_count", packets_sent, 1);
        cycles(2);

        // Counter wrap
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        model_cnt = 32'hFFFF_FFFF;
        @(negedge clock);
        check("preload_count", packets_sent, 32'hFFFF_FFFF);
        send(0, 3'd7, 4'd4, 20'h00001, 32'h0);
        @(negedge clock);
        check("wrap_count", packets_sent, 0);
        cycles(2);

        // Randomized traffic with random back-pressure
        core_ID   = 4'($urandom_range(0, 15));
        rand_done = 0;
        fork
            begin
                while (!rand_done) begin
                    @(negedge clock);
                    bus.full_in = 2'($urandom_range(0, 3));
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    send(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom),
                         20'($urandom), $urandom);
                    if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
                end
                rand_done = 1;
            end
        join
        @(negedge clock);
        bus.full_in = 2'b00;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clock);
        check("drain_pending", exp_q.size(), 0);
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_flit_packetizer.md
# mem_flit_packetizer

Converts memory requests from the cache side of a tile into wormhole flits for the router's local input port. Requests are queued in a small FIFO, given a flow ID, and bound to a free virtual channel. They then leave as a single flit (read) or a head+tail pair (write), under per-VC full back-pressure. The block sits between the cache request path and the router_wrapper local port, in the same tile as the memory/router system.

## Interface
Parameters:
- ID_BITS, 4, router/core ID width
- DATA_WIDTH, 32, flit payload width
- ADDRESS_BITS, 20, request address width
- MSG_BITS, 3, message-type width; MSG_BITS+ADDRESS_BITS <= DATA_WIDTH
- VC_BITS, 1, VC index width; VC_PER_PORTS = 1<<VC_BITS
- EXTRA, 2, extra flow bits; FLOW_BITS = 2*ID_BITS+EXTRA
- TYPE_BITS, 2, flit type width; FLIT_WIDTH = FLOW_BITS+TYPE_BITS+VC_BITS+DATA_WIDTH
- QUEUE_BITS, 2, request FIFO depth = 1<<QUEUE_BITS

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- core_ID  in  ID_BITS  source ID of this tile
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_write  in  1  1 = write (2 flits), 0 = read (1 flit)
- req_msg  in  MSG_BITS  message type
- req_dest  in  ID_BITS  destination router ID
- req_addr  in  ADDRESS_BITS  address
- req_data  in  DATA_WIDTH  write data (ignored for reads)
- flit_out  out  FLIT_WIDTH  flit to router local port
- valid_out  out  1  flit_out valid
- full_in  in  VC_PER_PORTS  per-VC full from router
- packets_sent  out  32  completed-packet counter

## Operation
- Flit layout, MSB to LSB: {flow, type, vc, data}. flow = {core_ID, dest, EXTRA'b0}.
- Type encoding: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11. This block never emits BODY.
- Head/single data = zero-extended {msg, addr}. Tail data = req_data.
- FIFO: push on req_valid && req_ready. req_ready = !fifo_full, combinational from registered count. Pop only when the last flit of a packet issues. Pointers wrap modulo depth.
- FSM states:
  - IDLE: if FIFO non-empty and some VC has full_in=0, lock vc = lowest such index and issue the first flit.
    - Read: SINGLE flit, pop, stay IDLE.
    - Write: HEAD flit, go TAIL.
    - No free VC: valid_out=0, stay IDLE.
  - TAIL: if full_in[vc]=0, issue TAIL, pop, go IDLE; else valid_out=0 and stay. The VC stays locked for the whole packet (wormhole) even if other VCs free up.
- packets_sent increments on each SINGLE or TAIL issue and wraps at 2^32.
- Simultaneous push and pop on a full FIFO: the pop frees the slot next cycle only; req_ready reflects the count at the start of the cycle.

## Timing
- Reset (async) values: valid_out=0, flit_out=0, packets_sent=0, FSM=IDLE, FIFO empty, req_ready=1. A partial packet is discarded; the router is reset at the same time.
- flit_out/valid_out are registered. A flit is valid in cycle N+1 only if full_in for its VC was 0 at edge N. The router's full_in carries one slot of slack.
- Latency: request accepted at edge N → in FIFO at N+1 → first flit valid in cycle N+2.
- Throughput: reads 1 packet/cycle; writes 1 packet per 2 cycles with no back-pressure.
- valid_out is high for exactly one cycle per flit. When idle, flit_out holds its last value.

## Test plan
- Reset then single read (core_ID=1, dest=5, msg=3, addr=0x12345): SINGLE flit valid 2 cycles after accept, flow=0x054 (ID_BITS=4, EXTRA=2), data=0x00312345, vc=0, packets_sent=1.
- Write (dest=2, addr=0x00010, data=0xDEADBEEF), full_in=0: HEAD then TAIL on consecutive cycles, same vc, tail data=0xDEADBEEF.
- Write with full_in[0]=1 and full_in[1]=0 at start: packet on vc=1. Raise full_in[1] after HEAD for 3 cycles: TAIL delayed 3 cycles; no flit on vc 0.
- Both VCs full while 5 reads are offered: FIFO takes 4, req_ready=0 on the 5th. Release full: 4 SINGLE flits on consecutive cycles, then the 5th is accepted.
- Assert reset between HEAD and TAIL: valid_out=0 immediately, FIFO empty, packets_sent=0. The next request starts with a fresh SINGLE/HEAD flit.
- Preload packets_sent near wrap via 2^32-1 issues (or force): the next packet reads 0.
